// File: rtl/mac_reg_bank.sv
// DEPTH x WIDTH operand/tap register bank with load, shift, hold and clear. Reads have 1-cycle latency.
// Writes take effect on the next edge. There is no backpressure: every op and read is accepted each cycle.
module mac_reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic             shift,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] q_out,
    output logic             q_ack,
    output logic             q_valid,
    output logic [DEPTH-1:0] valid_mask,
    output logic [AW:0]      count,
    output logic             full,
    output logic             cmd_err
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] entry [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = {1'b0, wr_addr} < DEPTH_W;
    assign rd_ok = {1'b0, rd_addr} < DEPTH_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            valid_mask <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            valid_mask <= '0;
        end else if (shift) begin
            entry[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) entry[i] <= entry[i-1];
            valid_mask <= {valid_mask[DEPTH-2:0], 1'b1};
        end else if (ld && wr_ok) begin
            entry[wr_addr]      <= d_in;
            valid_mask[wr_addr] <= 1'b1;
        end
    end

    // Shift wins over a colliding load; clr silently swallows both without flagging.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cmd_err <= 1'b0;
        else       cmd_err <= !clr && ld && (shift || !wr_ok);
    end

    // Read samples the pre-edge contents, so same-cycle writes are not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_out   <= '0;
            q_valid <= 1'b0;
            q_ack   <= 1'b0;
        end else begin
            q_ack <= rd_en;
            if (rd_en) begin
                if (rd_ok) begin
                    q_out   <= entry[rd_addr];
                    q_valid <= valid_mask[rd_addr];
                end else begin
                    q_out   <= '0;
                    q_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + (AW+1)'(valid_mask[i]);
    end

    assign full = &valid_mask;

endmodule
